// File: rtl/wb_arbiter_wrr.sv
// Weighted round-robin Wishbone B3 arbiter: whole cyc periods are granted to one master,
// with a watchdog that aborts slave accesses left without a response.
module wb_arbiter_wrr #(
  parameter int          NUM_MASTERS = 3,
  parameter int          aw          = 32,
  parameter int          dw          = 32,
  parameter logic [31:0] WEIGHTS     = 32'h121,
  parameter int          TIMEOUT     = 256
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [NUM_MASTERS*dw-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_ABORT} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  logic [3:0]             r_run;
  logic [WDW-1:0]         r_wd;

  logic [3:0]    w_wt;
  logic          w_cont;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_srch;
  logic [IW-1:0] w_next;
  logic          w_own;
  logic          w_stall;
  logic          w_expire;

  // A run count of 0 means no run is in progress (after reset), so the search path is taken.
  always_comb begin
    w_wt = WEIGHTS[4*r_last +: 4];
    if (w_wt == 4'd0) w_wt = 4'd1;
    w_cont  = (r_run != 4'd0) && (r_run < w_wt) && wbm_cyc_i[r_last];
    w_found = 1'b0;
    w_srch  = r_last;
    w_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_idx = IW'((int'(r_last) + k) % NUM_MASTERS);
      if (!w_found && wbm_cyc_i[w_idx]) begin
        w_found = 1'b1;
        w_srch  = w_idx;
      end
    end
    w_next = w_cont ? r_last : w_srch;
  end

  assign w_own     = (r_state == S_OWN);
  assign wbs_adr_o = wbm_adr_i[r_owner*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[r_owner*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[r_owner*4 +: 4];
  assign wbs_cti_o = wbm_cti_i[r_owner*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[r_owner*2 +: 2];
  assign wbs_we_o  = w_own & wbm_we_i[r_owner];
  assign wbs_cyc_o = w_own & wbm_cyc_i[r_owner];
  assign wbs_stb_o = wbs_cyc_o & wbm_stb_i[r_owner];

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign grant_o   = r_grant;
  assign timeout_o = (r_state == S_ABORT);

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (w_own) begin
      wbm_ack_o[r_owner] = wbs_ack_i;
      wbm_err_o[r_owner] = wbs_err_i;
      wbm_rty_o[r_owner] = wbs_rty_i;
    end else if (r_state == S_ABORT) begin
      wbm_err_o[r_owner] = 1'b1;
    end
  end

  assign w_stall  = wbs_stb_o & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
  assign w_expire = (TIMEOUT != 0) && (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_run   <= 4'd0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (|wbm_cyc_i) begin
            r_state <= S_OWN;
            r_owner <= w_next;
            r_grant <= ONE << w_next;
            r_run   <= w_cont ? r_run + 4'd1 : 4'd1;
          end
        end
        S_OWN: begin
          // Dropping cyc takes priority over a watchdog expiry in the same cycle.
          if (!wbm_cyc_i[r_owner]) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
            r_wd    <= '0;
          end else if (w_stall) begin
            if (w_expire) begin
              r_state <= S_ABORT;
              r_wd    <= '0;
            end else if (r_wd != '1) begin
              r_wd <= r_wd + 1'b1;
            end
          end else begin
            r_wd <= '0;
          end
        end
        S_ABORT: begin
          r_wd <= '0;
          if (wbm_cyc_i[r_owner]) begin
            r_state <= S_OWN;
          end else begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= r_owner;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_wrr.sv
// Bench for wb_arbiter_wrr: random master/slave traffic, scoreboarded responses and
// a list-based weighted round-robin reference for grant order.
module tb_wb_arbiter_wrr;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*4-1:0]  wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arbiter_wrr #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .WEIGHTS(32'h121), .TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {int id; int kind; logic [DW-1:0] dat;} resp_t;
  typedef struct {int id; int cyc;} ab_t;
  typedef struct {int g; int idle;} glog_t;

  resp_t exp_q[$];
  ab_t   ab_q[$];
  glog_t glog[$];

  int checks = 0, errors = 0, cyc_cnt = 0;
  int wt_of[N] = '{1, 2, 1};

  int            pending[N], drop_at[N];
  bit            active[N], hold[N];
  logic [AW-1:0] m_adr[N];
  logic [DW-1:0] m_dat[N];
  logic          m_we[N];
  logic [3:0]    m_sel[N];
  logic [2:0]    m_cti[N];
  logic [1:0]    m_bte[N];
  logic [2:0]    cti_mode;
  logic [N-1:0]  resp_seen;

  bit s_mute, s_mix, s_busy;
  int s_lat, s_wait;

  int           mL, ms, idle_run;
  logic [N-1:0] pg, preq;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: masters update, then the slave reacts to what the arbiter presents.
  task automatic step();
    int id, kind;
    @(posedge wb_clk_i); #1;
    cyc_cnt++;
    for (int i = 0; i < N; i++) begin
      if (active[i] && (drop_at[i] == cyc_cnt || (resp_seen[i] && !hold[i]))) begin
        active[i]  = 1'b0;
        drop_at[i] = -1;
      end else if (!active[i] && pending[i] > 0) begin
        active[i] = 1'b1;
        pending[i]--;
        m_adr[i] = {4'(i), 28'($urandom)};
        m_dat[i] = $urandom;
        m_we[i]  = 1'($urandom_range(0, 1));
        m_sel[i] = 4'($urandom);
        m_cti[i] = cti_mode;
        m_bte[i] = 2'($urandom);
      end
      wbm_cyc_i[i] = active[i];
      wbm_stb_i[i] = active[i];
      wbm_we_i[i]  = m_we[i];
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = m_dat[i];
      wbm_sel_i[i*4 +: 4]   = m_sel[i];
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = m_bte[i];
    end
    #1;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    if (!(wbs_cyc_o && wbs_stb_o)) s_busy = 1'b0;
    else if (!s_mute) begin
      if (!s_busy) begin
        s_busy = 1'b1;
        s_wait = (s_lat < 0) ? int'($urandom_range(0, 3)) : s_lat;
      end
      if (s_wait == 0) begin
        id = int'(wbs_adr_o[AW-1:AW-4]);
        if (id >= N) chk("slv_id_range", id, 0);
        else begin
          chk("slv_req", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
              {m_adr[id], m_dat[id], m_sel[id], m_we[id], m_cti[id], m_bte[id]});
          chk("slv_owner", grant_o, N'(1) << id);
        end
        kind = 0;
        if (s_mix) begin
          kind = int'($urandom_range(0, 5));
          if (kind < 4) kind = 0; else kind = kind - 3;
        end
        wbs_dat_i = $urandom;
        wbs_ack_i = (kind == 0);
        wbs_err_i = (kind == 1);
        wbs_rty_i = (kind == 2);
        exp_q.push_back('{id, kind, wbs_dat_i});
        s_busy = 1'b0;
      end else s_wait--;
    end
    #1;
    resp_seen = wbm_ack_o | wbm_err_o | wbm_rty_o;
  endtask

  task automatic drain();
    int k;
    bit busy;
    busy = 1'b1;
    for (k = 0; k < 2000 && busy; k++) begin
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (pending[i] > 0 || active[i]) busy = 1'b1;
      if (busy) step();
    end
    chk("drain_bound", busy, 0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    step(); step();
    wb_rst_i = 1'b0;
  endtask

  // Monitor: responses against the scoreboard, new grants against the reference.
  always @(negedge wb_clk_i) begin : mon
    int w, wt, gi;
    int order[$];
    resp_t r;
    ab_t   a;
    if (wb_rst_i) begin
      mL = N - 1; ms = 0; pg = '0; idle_run = 0;
    end else begin
      if (timeout_o) begin
        if (ab_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout actual=err%b required=none", wbm_err_o);
        end else begin
          a = ab_q.pop_front();
          chk("abort_cycle", cyc_cnt, a.cyc);
          chk("abort_resp", {wbm_err_o, wbm_ack_o, wbm_rty_o}, {N'(1) << a.id, N'(0), N'(0)});
          chk("abort_slv_idle", {wbs_cyc_o, wbs_stb_o}, 0);
        end
      end else if (|{wbm_ack_o, wbm_err_o, wbm_rty_o}) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=ack%b/err%b/rty%b required=none",
                   wbm_ack_o, wbm_err_o, wbm_rty_o);
        end else begin
          r = exp_q.pop_front();
          chk("resp_route", {wbm_ack_o, wbm_err_o, wbm_rty_o},
              {(r.kind == 0) ? N'(1) << r.id : N'(0), (r.kind == 1) ? N'(1) << r.id : N'(0),
               (r.kind == 2) ? N'(1) << r.id : N'(0)});
          chk("resp_data", wbm_dat_o[r.id*DW +: DW], r.dat);
        end
      end
      if (grant_o != '0 && pg == '0) begin
        w = -1;
        if (ms > 0 && ms < wt_of[mL] && preq[mL]) begin
          w = mL; ms++;
        end else begin
          order.delete();
          for (int k = 1; k <= N; k++) order.push_back((mL + k) % N);
          foreach (order[k]) if (w < 0 && preq[order[k]]) w = order[k];
          ms = 1;
        end
        if (w < 0) chk("grant_without_req", grant_o, 0);
        else begin
          chk("grant_wrr", grant_o, N'(1) << w);
          mL = w;
        end
        gi = -1;
        for (int k = 0; k < N; k++) if (grant_o == (N'(1) << k)) gi = k;
        glog.push_back('{gi, idle_run});
        idle_run = 0;
      end else if (grant_o == '0) idle_run++;
      pg = grant_o;
    end
    preq = wbm_cyc_i;
  end

  initial begin
    int t, ack_cyc;
    int seq[8] = '{0, 1, 1, 2, 0, 1, 1, 2};
    wb_rst_i = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0; wbm_cyc_i = '0;
    wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    resp_seen = '0; cti_mode = 3'b000;
    s_mute = 1'b0; s_mix = 1'b0; s_busy = 1'b0; s_lat = -1; s_wait = 0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 0; drop_at[i] = -1; active[i] = 1'b0; hold[i] = 1'b0;
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0; m_sel[i] = '0; m_cti[i] = '0; m_bte[i] = '0;
    end
    repeat (3) step();
    chk("rst_grant", grant_o, 0);
    chk("rst_slv_ctrl", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 0);
    chk("rst_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    chk("rst_timeout", timeout_o, 0);
    wb_rst_i = 1'b0;
    step();

    // Single read from master 1, slave answers two cycles after stb.
    s_lat = 2; pending[1] = 1;
    step(); t = cyc_cnt;
    step(); chk("p1_grant", grant_o, 3'b010);
    ack_cyc = -1;
    for (int k = 0; k < 10 && ack_cyc < 0; k++) begin
      step();
      if (wbm_ack_o != '0) ack_cyc = cyc_cnt;
    end
    chk("p1_ack_vec", wbm_ack_o, 3'b010);
    chk("p1_ack_cycle", ack_cyc, t + 3);
    step(); chk("p1_ack_one_cycle", wbm_ack_o, 0);
    step(); chk("p1_grant_clear", grant_o, 0);
    drain();

    // Back-to-back traffic from all masters with the default weights.
    do_reset();
    s_lat = -1; glog.delete();
    for (int i = 0; i < N; i++) pending[i] = 4;
    drain();
    chk("p2_count", glog.size() >= 8, 1);
    for (int k = 0; k < 8 && k < glog.size(); k++) begin
      chk($sformatf("p2_seq%0d", k), glog[k].g, seq[k]);
      if (k > 0) chk($sformatf("p2_idle%0d", k), glog[k].idle, 1);
    end

    // Master 0 alone: regains the bus every time with one dead cycle.
    glog.delete(); pending[0] = 5;
    drain();
    chk("p3_count", glog.size(), 5);
    foreach (glog[k]) begin
      chk($sformatf("p3_owner%0d", k), glog[k].g, 0);
      if (k > 0) chk($sformatf("p3_idle%0d", k), glog[k].idle, 1);
    end

    // Mute slave: master 2 holds its strobe through two watchdog aborts.
    s_mute = 1'b1; hold[2] = 1'b1; pending[2] = 1;
    step(); t = cyc_cnt;
    ab_q.push_back('{2, t + 9});
    ab_q.push_back('{2, t + 18});
    while (cyc_cnt < t + 18) step();
    hold[2] = 1'b0;
    repeat (3) step();
    chk("p4_aborts_seen", ab_q.size(), 0);
    chk("p4_grant_clear", grant_o, 0);
    drain();

    // Master 1 drops cyc in the cycle the watchdog would expire.
    pending[1] = 1;
    step(); t = cyc_cnt;
    drop_at[1] = t + 8;
    while (cyc_cnt < t + 8) step();
    chk("p5_still_own", grant_o, 3'b010);
    step();
    chk("p5_idle_grant", grant_o, 0);
    chk("p5_no_timeout", {timeout_o, wbm_err_o}, 0);
    drain();

    // Reset while master 0 owns a burst.
    cti_mode = 3'b010; pending[0] = 1;
    step(); step(); step();
    chk("p6_own", grant_o, 3'b001);
    chk("p6_burst", {wbs_cyc_o, wbs_cti_o}, {1'b1, 3'b010});
    wb_rst_i = 1'b1;
    step();
    chk("p6_rst_slv_cyc", wbs_cyc_o, 0);
    chk("p6_rst_grant", grant_o, 0);
    active[0] = 1'b0;
    step();
    wb_rst_i = 1'b0; cti_mode = 3'b000; s_mute = 1'b0; glog.delete();
    pending[2] = 1;
    drain();
    chk("p6_first_after_rst", (glog.size() > 0) ? glog[0].g : -1, 2);

    // Random traffic with mixed slave responses.
    s_mix = 1'b1; s_lat = -1;
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 3) == 0) pending[$urandom_range(0, N-1)] += int'($urandom_range(1, 3));
      step();
    end
    drain();

    chk("end_resp_q_empty", exp_q.size(), 0);
    chk("end_abort_q_empty", ab_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
